// File: rtl/rx_frame_aggregator.sv
// Round-robin frame aggregator: pulls whole frames from N per-port RX FIFO pairs, strips the
// trailer, polices length/error flags and writes data plus a tagged pointer to shared FIFOs.
module rx_frame_aggregator #(
  parameter int unsigned NPORT     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned LENW      = 13,
  parameter int unsigned OLENW     = 11,
  parameter int unsigned CNTW      = 14,
  parameter int unsigned BP_THRESH = 14866,
  parameter int unsigned STRIP     = 4,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NPORT-1:0]       port_en,
  input  logic [NPORT-1:0]       rx_ptr_empty,
  output logic [NPORT-1:0]       rx_ptr_rd,
  input  logic [16*NPORT-1:0]    rx_ptr_dout,
  output logic [NPORT-1:0]       rx_data_rd,
  input  logic [DW*NPORT-1:0]    rx_data_dout,
  input  logic [CNTW-1:0]        agg_data_cnt,
  output logic                   agg_data_wr,
  output logic [DW-1:0]          agg_data_din,
  input  logic                   agg_ptr_full,
  output logic                   agg_ptr_wr,
  output logic [NPORT+OLENW:0]   agg_ptr_din,
  output logic [15:0]            drop_cnt,
  output logic [31:0]            frame_cnt,
  output logic                   busy
);

  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CNTW-1:0] BpThr    = CNTW'(BP_THRESH);
  localparam logic [LENW-1:0] MinLen   = LENW'(MIN_LEN);
  localparam logic [LENW-1:0] MaxLen   = LENW'(MAX_LEN);
  localparam logic [LENW-1:0] StripLen = LENW'(STRIP);

  typedef enum logic [2:0] {StIdle, StPtrRd, StPtrLat, StData, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [PW-1:0]          rr_q, sel_q;
  logic [LENW-1:0]        len_q, rd_cnt_q;
  logic                   err_q, keep_q, rd_d1_q, drain_q;
  logic [NPORT-1:0]       rx_ptr_rd_q, rx_data_rd_q;
  logic                   agg_data_wr_q, agg_ptr_wr_q, busy_q;
  logic [DW-1:0]          agg_data_din_q;
  logic [NPORT+OLENW:0]   agg_ptr_din_q;
  logic [15:0]            drop_cnt_q;
  logic [31:0]            frame_cnt_q;

  logic                   bp, hit;
  logic [PW-1:0]          grant_idx, rr_d;
  int unsigned            arb_j;
  logic [15:0]            ptr_word;
  logic [DW-1:0]          data_byte;
  logic [LENW-1:0]        ptr_len, done_len;
  logic                   ptr_err, done_go, done_err;
  logic [NPORT-1:0]       sel_onehot, grant_onehot;
  logic [OLENW-1:0]       stripped;
  logic [LENW:0]          keep_sum;
  logic                   unused_ptr_bits;

  assign bp = (agg_data_cnt > BpThr) | agg_ptr_full;

  // First enabled, non-empty port at or after the round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    grant_idx = '0;
    arb_j     = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      arb_j = 32'(rr_q) + i;
      if (arb_j >= NPORT) arb_j = arb_j - NPORT;
      if (!hit && port_en[arb_j[PW-1:0]] && !rx_ptr_empty[arb_j[PW-1:0]]) begin
        hit       = 1'b1;
        grant_idx = arb_j[PW-1:0];
      end
    end
  end

  assign rr_d         = (grant_idx == PW'(NPORT - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_onehot = NPORT'(1) << grant_idx;
  assign sel_onehot   = NPORT'(1) << sel_q;

  always_comb begin
    ptr_word  = '0;
    data_byte = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (sel_q == PW'(k)) begin
        ptr_word  = rx_ptr_dout[16*k +: 16];
        data_byte = rx_data_dout[DW*k +: DW];
      end
    end
  end

  assign ptr_len         = ptr_word[LENW-1:0];
  assign ptr_err         = ptr_word[15] | ptr_word[14] | (ptr_len < MinLen) | (ptr_len > MaxLen);
  assign unused_ptr_bits = ^ptr_word;

  // Zero-length frames skip DATA and finish straight from PTR_LAT.
  assign done_go  = ((state_q == StPtrLat) && (ptr_len == '0)) || ((state_q == StDrain) && drain_q);
  assign done_err = (state_q == StPtrLat) ? ptr_err : err_q;
  assign done_len = (state_q == StPtrLat) ? ptr_len : len_q;
  assign stripped = OLENW'(done_len - StripLen);
  assign keep_sum = {1'b0, rd_cnt_q} + {1'b0, StripLen};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      rr_q           <= '0;
      sel_q          <= '0;
      len_q          <= '0;
      rd_cnt_q       <= '0;
      err_q          <= 1'b0;
      keep_q         <= 1'b0;
      rd_d1_q        <= 1'b0;
      drain_q        <= 1'b0;
      rx_ptr_rd_q    <= '0;
      rx_data_rd_q   <= '0;
      agg_data_wr_q  <= 1'b0;
      agg_data_din_q <= '0;
      agg_ptr_wr_q   <= 1'b0;
      agg_ptr_din_q  <= '0;
      drop_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      rx_ptr_rd_q   <= '0;
      agg_ptr_wr_q  <= 1'b0;
      // Two-stage write pipeline: source dout lands one cycle after the strobe.
      rd_d1_q       <= (|rx_data_rd_q) & keep_q;
      agg_data_wr_q <= rd_d1_q;
      if (rd_d1_q) agg_data_din_q <= data_byte;

      if (done_go) begin
        if (!done_err) begin
          agg_ptr_wr_q  <= 1'b1;
          agg_ptr_din_q <= {1'b0, sel_onehot, stripped};
          frame_cnt_q   <= frame_cnt_q + 32'd1;
        end else if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_q <= drop_cnt_q + 16'd1;
        end
      end

      case (state_q)
        StIdle: begin
          if (!bp && hit) begin
            sel_q       <= grant_idx;
            rr_q        <= rr_d;
            rx_ptr_rd_q <= grant_onehot;
            busy_q      <= 1'b1;
            state_q     <= StPtrRd;
          end
        end
        StPtrRd: state_q <= StPtrLat;
        StPtrLat: begin
          len_q <= ptr_len;
          err_q <= ptr_err;
          if (ptr_len == '0) begin
            state_q <= StDone;
          end else begin
            rx_data_rd_q <= sel_onehot;
            rd_cnt_q     <= LENW'(1);
            keep_q       <= !ptr_err && (StripLen < ptr_len);
            state_q      <= StData;
          end
        end
        StData: begin
          if (rd_cnt_q == len_q) begin
            rx_data_rd_q <= '0;
            keep_q       <= 1'b0;
            drain_q      <= 1'b0;
            state_q      <= StDrain;
          end else begin
            keep_q   <= !err_q && (keep_sum < {1'b0, len_q});
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q) state_q <= StDone;
          else drain_q <= 1'b1;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_ptr_rd    = rx_ptr_rd_q;
  assign rx_data_rd   = rx_data_rd_q;
  assign agg_data_wr  = agg_data_wr_q;
  assign agg_data_din = agg_data_din_q;
  assign agg_ptr_wr   = agg_ptr_wr_q;
  assign agg_ptr_din  = agg_ptr_din_q;
  assign drop_cnt     = drop_cnt_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = busy_q;

endmodule
